// File: rtl/aes_xts_block_sequencer.sv
// rtl/aes_xts_block_sequencer.sv - AES-XTS-256 key/tweak/data block control sequencer
// Optional key reuse across data units: define AES_XTS_KEY_CACHE_EN.
module aes_xts_block_sequencer #(
   parameter int NR = 14,
   parameter int AW = 4,
   parameter int CW = 8
) (
   input  logic          inClk,
   input  logic          inRst,
   input  logic          inStart,
   input  logic          inDecrypt,
   input  logic [CW-1:0] inBlockCount,
   input  logic          inKeyNew,
   input  logic          inKeySchBusy,
   input  logic          inAesEncBusy,
   input  logic          inAesEncDecBusy,
   input  logic          inDataValid,
   output logic          outBusy,
   output logic          outKeySchStart,
   output logic          outKeySel,
   output logic          outKeyMem1Wr,
   output logic          outKeyMem2Wr,
   output logic          outKeyMem1Rd,
   output logic          outKeyMem2Rd,
   output logic [AW-1:0] outKeyAddr,
   output logic          outTweakStart,
   output logic          outDataStart,
   output logic          outTweakMul,
   output logic          outBlockDone,
   output logic          outDone
);

   typedef enum logic [2:0] {IDLE, K1, K2, TWK, DWAIT, DRUN, FIN} stateT;

   stateT         state, stateNext;
   logic [AW-1:0] rc, rcNext, addrNext;
   logic          seenBusy;
   logic          entry;
   logic          decQ;
   logic [CW-1:0] totalQ;
   logic [CW-1:0] blkCnt;
   logic          phaseBusy;
   logic          phaseFall;
   logic          lastBlock;
   logic          skipKeys;

`ifdef AES_XTS_KEY_CACHE_EN
   logic keyValid;
   assign skipKeys = !inKeyNew && keyValid;
`else
   logic unusedKeyNew;
   assign unusedKeyNew = inKeyNew;
   assign skipKeys     = 1'b0;
`endif

   assign lastBlock = (blkCnt + CW'(1)) == totalQ;

   always_comb begin
      stateNext = state;
      phaseBusy = 1'b0;
      case (state)
         K1, K2:  phaseBusy = inKeySchBusy;
         TWK:     phaseBusy = inAesEncBusy;
         DRUN:    phaseBusy = inAesEncDecBusy;
         default: phaseBusy = 1'b0;
      endcase
      // A phase ends on the first idle cycle after its engine has been seen busy.
      phaseFall = seenBusy && !phaseBusy;

      case (state)
         IDLE:    if (inStart) stateNext = skipKeys ? TWK : K1;
         K1:      if (phaseFall) stateNext = K2;
         K2:      if (phaseFall) stateNext = TWK;
         TWK:     if (phaseFall) stateNext = (totalQ == '0) ? FIN : DWAIT;
         DWAIT:   if (inDataValid) stateNext = DRUN;
         DRUN:    if (phaseFall) stateNext = lastBlock ? FIN : DWAIT;
         FIN:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase

      if (stateNext != state) rcNext = '0;
      else if (phaseBusy && rc != AW'(NR)) rcNext = rc + AW'(1);
      else rcNext = rc;

      // Decrypt walks the schedule backwards so round NR is applied first.
      case (stateNext)
         K1, K2, TWK: addrNext = rcNext;
         DRUN:        addrNext = decQ ? AW'(NR) - rcNext : rcNext;
         default:     addrNext = '0;
      endcase
   end

   always_comb begin
      outBusy      = state != IDLE;
      outKeySel    = state == K2;
      outKeyMem1Wr = (state == K1) && inKeySchBusy;
      outKeyMem2Wr = (state == K2) && inKeySchBusy;
      outKeyMem2Rd = (state == TWK) && inAesEncBusy;
      outKeyMem1Rd = (state == DRUN) && inAesEncDecBusy;
      outBlockDone = (state == DRUN) && phaseFall;
      outTweakMul  = (state == DRUN) && phaseFall && !lastBlock;
      outDone      = state == FIN;
   end

   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         state          <= IDLE;
         rc             <= '0;
         seenBusy       <= 1'b0;
         entry          <= 1'b0;
         decQ           <= 1'b0;
         totalQ         <= '0;
         blkCnt         <= '0;
         outKeyAddr     <= '0;
         outKeySchStart <= 1'b0;
         outTweakStart  <= 1'b0;
         outDataStart   <= 1'b0;
      end else begin
         state          <= stateNext;
         rc             <= rcNext;
         entry          <= stateNext != state;
         seenBusy       <= (stateNext != state) ? 1'b0 : (seenBusy || phaseBusy);
         outKeyAddr     <= addrNext;
         outKeySchStart <= entry && (state == K1 || state == K2);
         outTweakStart  <= entry && (state == TWK);
         outDataStart   <= entry && (state == DRUN);
         if (state == IDLE && inStart) begin
            decQ   <= inDecrypt;
            totalQ <= inBlockCount;
            blkCnt <= '0;
         end else if (state == DRUN && phaseFall) begin
            blkCnt <= blkCnt + CW'(1);
         end
      end
   end

`ifdef AES_XTS_KEY_CACHE_EN
   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) keyValid <= 1'b0;
      else if (state == FIN) keyValid <= 1'b1;
      else if (state == IDLE && inStart && inKeyNew) keyValid <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_aes_xts_block_sequencer.sv
// tb/tb_aes_xts_block_sequencer.sv - directed self-checking bench for aes_xts_block_sequencer
module tb_aes_xts_block_sequencer;

   localparam int NR = 14;
   localparam int AW = 4;
   localparam int CW = 8;

   logic          clk = 0;
   logic          rst = 1;
   logic          inStart = 0, inDecrypt = 0, inKeyNew = 1, inDataValid = 1;
   logic [CW-1:0] inBlockCount = 0;
   logic          engBusy [3];
   logic          outBusy, outKeySchStart, outKeySel, outKeyMem1Wr, outKeyMem2Wr;
   logic          outKeyMem1Rd, outKeyMem2Rd, outTweakStart, outDataStart;
   logic          outTweakMul, outBlockDone, outDone;
   logic [AW-1:0] outKeyAddr;
   logic [2:0]    engStart;

   int total = 0, bad = 0;
   int busyLen = 15;
   logic [AW-1:0] q1w[$], q2w[$], q1r[$], q2r[$];
   int nSch, nTwk, nDat, nMul, nBlk, nDone;

   always #5 clk = ~clk;

   aes_xts_block_sequencer #(.NR(NR), .AW(AW), .CW(CW)) dut (
      .inClk(clk), .inRst(rst), .inStart(inStart), .inDecrypt(inDecrypt),
      .inBlockCount(inBlockCount), .inKeyNew(inKeyNew),
      .inKeySchBusy(engBusy[0]), .inAesEncBusy(engBusy[1]), .inAesEncDecBusy(engBusy[2]),
      .inDataValid(inDataValid), .outBusy(outBusy), .outKeySchStart(outKeySchStart),
      .outKeySel(outKeySel), .outKeyMem1Wr(outKeyMem1Wr), .outKeyMem2Wr(outKeyMem2Wr),
      .outKeyMem1Rd(outKeyMem1Rd), .outKeyMem2Rd(outKeyMem2Rd), .outKeyAddr(outKeyAddr),
      .outTweakStart(outTweakStart), .outDataStart(outDataStart), .outTweakMul(outTweakMul),
      .outBlockDone(outBlockDone), .outDone(outDone)
   );

   assign engStart = {outDataStart, outTweakStart, outKeySchStart};

   // Engine model: busy for busyLen cycles starting the cycle after its start pulse.
   task automatic engine(input int id);
      forever begin
         @(posedge clk); #1;
         if (engStart[id] && !rst) begin
            @(posedge clk); #1;
            if (!rst) begin
               engBusy[id] = 1'b1;
               for (int k = 0; k < busyLen && !rst; k++) begin
                  @(posedge clk); #1;
               end
               engBusy[id] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) engBusy[i] = 1'b0;
      fork
         engine(0);
         engine(1);
         engine(2);
      join
   end

   initial forever begin
      @(negedge clk);
      if (outKeyMem1Wr) q1w.push_back(outKeyAddr);
      if (outKeyMem2Wr) q2w.push_back(outKeyAddr);
      if (outKeyMem1Rd) q1r.push_back(outKeyAddr);
      if (outKeyMem2Rd) q2r.push_back(outKeyAddr);
      nSch  += int'(outKeySchStart);
      nTwk  += int'(outTweakStart);
      nDat  += int'(outDataStart);
      nMul  += int'(outTweakMul);
      nBlk  += int'(outBlockDone);
      nDone += int'(outDone);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Count of entries differing from the expected per-block address walk, plus size error.
   function automatic int seqErr(input logic [AW-1:0] q[$], input bit desc, input int reps, input int len);
      int e = 0;
      int a;
      if (q.size() != reps * len) return 1000 + q.size();
      for (int r = 0; r < reps; r++)
         for (int i = 0; i < len; i++) begin
            a = (i < NR) ? i : NR;
            if (desc) a = NR - a;
            if (q[r * len + i] !== AW'(a)) e++;
         end
      return e;
   endfunction

   task automatic clearLog();
      q1w.delete(); q2w.delete(); q1r.delete(); q2r.delete();
      nSch = 0; nTwk = 0; nDat = 0; nMul = 0; nBlk = 0; nDone = 0;
   endtask

   task automatic pulseStart(input logic dec, input int cnt, input logic keyNew);
      @(negedge clk);
      inDecrypt = dec; inBlockCount = CW'(cnt); inKeyNew = keyNew; inStart = 1;
      @(negedge clk); #1;
      inStart = 0;
   endtask

   task automatic waitDone(input string tag, input int limit);
      int n = 0;
      while (!outDone && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      chk(tag, n < limit, 1);
      @(negedge clk); #1;
   endtask

   task automatic allIdle(input string tag);
      chk(tag, {outBusy, outKeySchStart, outKeySel, outKeyMem1Wr, outKeyMem2Wr, outKeyMem1Rd,
                outKeyMem2Rd, outTweakStart, outDataStart, outTweakMul, outBlockDone, outDone,
                outKeyAddr}, 0);
   endtask

   initial begin
      int n;
      clearLog();
      repeat (3) @(negedge clk);
      #1 allIdle("resetOutputs");
      rst = 0;

      // Encrypt one block; start-pulse latency check.
      clearLog();
      pulseStart(0, 1, 1);
      chk("busyAfterStart", outBusy, 1);
      chk("schStartEntryCycle", outKeySchStart, 0);
      @(negedge clk); #1;
      chk("schStartSecondCycle", outKeySchStart, 1);
      chk("keySelK1", outKeySel, 0);
      waitDone("encDone1", 400);
      chk("enc1 mem1 writes", seqErr(q1w, 0, 1, 15), 0);
      chk("enc1 mem2 writes", seqErr(q2w, 0, 1, 15), 0);
      chk("enc1 mem2 reads", seqErr(q2r, 0, 1, 15), 0);
      chk("enc1 mem1 reads", seqErr(q1r, 0, 1, 15), 0);
      chk("enc1 blockDone", nBlk, 1);
      chk("enc1 tweakMul", nMul, 0);
      chk("enc1 done", nDone, 1);
      chk("enc1 schStarts", nSch, 2);
      chk("enc1 idle after", outBusy, 0);

      // Decrypt three blocks.
      clearLog();
      pulseStart(1, 3, 1);
      waitDone("dec3Done", 600);
      chk("dec3 mem1 reads", seqErr(q1r, 1, 3, 15), 0);
      chk("dec3 blockDone", nBlk, 3);
      chk("dec3 tweakMul", nMul, 2);
      chk("dec3 dataStart", nDat, 3);
      chk("dec3 done", nDone, 1);

      // Data not valid: sequencer parks in DWAIT.
      clearLog();
      inDataValid = 0;
      pulseStart(0, 2, 1);
      n = 0;
      while (nTwk == 0 && n < 200) begin @(negedge clk); #1; n++; end
      chk("dwait tweakStart seen", nTwk, 1);
      repeat (20) @(negedge clk);
      repeat (10) @(negedge clk);
      #1;
      chk("dwait no dataStart", nDat, 0);
      chk("dwait no blockDone", nBlk, 0);
      chk("dwait busy", outBusy, 1);
      inDataValid = 1;
      waitDone("dwaitDone", 400);
      chk("dwait dataStart", nDat, 2);
      chk("dwait blockDone", nBlk, 2);
      chk("dwait tweakMul", nMul, 1);

      // Start during DRUN is ignored.
      clearLog();
      pulseStart(1, 2, 1);
      n = 0;
      while (!engBusy[2] && n < 200) begin @(negedge clk); #1; n++; end
      chk("drun reached", engBusy[2], 1);
      pulseStart(0, 5, 1);
      waitDone("ignoreDone", 400);
      chk("ignore blockDone", nBlk, 2);
      chk("ignore direction", seqErr(q1r, 1, 2, 15), 0);
      chk("ignore done", nDone, 1);
      @(negedge clk); #1;
      chk("ignore no restart", outBusy, 0);

      // Zero blocks: TWK straight to FIN.
      clearLog();
      pulseStart(0, 0, 1);
      waitDone("zeroDone", 300);
      chk("zero tweakStart", nTwk, 1);
      chk("zero dataStart", nDat, 0);
      chk("zero blockDone", nBlk, 0);

      // Long busy: round counter saturates at NR.
      clearLog();
      busyLen = 17;
      pulseStart(0, 1, 1);
      waitDone("satDone", 400);
      chk("sat mem1 writes", seqErr(q1w, 0, 1, 17), 0);
      chk("sat mem1 reads", seqErr(q1r, 0, 1, 17), 0);
      busyLen = 15;

      // Reset during K2 while the key schedule is busy.
      clearLog();
      pulseStart(0, 1, 1);
      n = 0;
      while (!outKeyMem2Wr && n < 200) begin @(negedge clk); #1; n++; end
      repeat (3) @(negedge clk);
      #1;
      chk("k2 busy before reset", {outKeySel, engBusy[0]}, 3);
      rst = 1;
      @(negedge clk); #1;
      allIdle("resetInK2");
      rst = 0;
      clearLog();
      pulseStart(0, 1, 1);
      @(negedge clk); #1;
      chk("restart schStart", outKeySchStart, 1);
      waitDone("restartDone", 400);
      chk("restart mem1 writes", seqErr(q1w, 0, 1, 15), 0);
      chk("restart schStarts", nSch, 2);

      // Second start with unchanged keys.
      clearLog();
      pulseStart(0, 1, 0);
`ifdef AES_XTS_KEY_CACHE_EN
      chk("cache tweakStart entry", outTweakStart, 0);
      @(negedge clk); #1;
      chk("cache tweakStart next", outTweakStart, 1);
      waitDone("cacheDone", 400);
      chk("cache schStarts", nSch, 0);
      chk("cache mem writes", q1w.size() + q2w.size(), 0);
      clearLog();
      pulseStart(0, 1, 1);
      waitDone("cacheNewDone", 400);
      chk("cache keyNew schStarts", nSch, 2);
`else
      waitDone("noCacheDone", 400);
      chk("noCache schStarts", nSch, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

endmodule
